// File: rtl/sevseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : sevseg_scan_driver
// Purpose : Time-multiplexed 7-segment scan driver with double-buffered nibbles,
//           hex decode, per-digit blink and leading-zero blanking.
//           Optional decimal point enabled by macro SEVSEG_DP_EN.
// Revision: 1.0
// ============================================================================
module sevseg_scan_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [4*NUM_DIGITS-1:0]   digits_in,
   input  logic                      load,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   input  logic                      blank_lz,
`ifdef SEVSEG_DP_EN
   input  logic [NUM_DIGITS-1:0]     dp_mask,
   output logic                      dp,
`endif
   output logic [0:6]                seg,
   output logic [NUM_DIGITS-1:0]     digit
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [RW-1:0]             ref_q, ref_d;
   logic [BW-1:0]             blink_cnt_q, blink_cnt_d;
   logic                      blink_phase_q, blink_phase_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
   logic [4*NUM_DIGITS-1:0]   active_q, active_d;
   logic [6:0]                seg_q, seg_d;
   logic [NUM_DIGITS-1:0]     digit_q, digit_d;
   logic                      tick;
   logic                      frame_start;
   logic                      blanked;
   logic [3:0]                nib;
   logic [NUM_DIGITS-1:0]     zero_from;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;  default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   always_comb begin
      tick        = (ref_q == REF_LAST);
      ref_d       = tick ? '0 : ref_q + 1'b1;
      idx_d       = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      frame_start = tick && (idx_d == '0);
      shadow_d    = load ? digits_in : shadow_q;
      // Frame start copies the pre-load shadow, so a same-edge load waits a frame.
      active_d    = frame_start ? shadow_q : active_q;
   end

   // zero_from[k]: nibbles k..top of the displayed frame are all zero.
   always_comb begin
      zero_from = '0;
      zero_from[NUM_DIGITS-1] = (active_d[4*(NUM_DIGITS-1) +: 4] == 4'd0);
      for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
         zero_from[k] = (active_d[4*k +: 4] == 4'd0) && zero_from[k+1];
      end
   end

   always_comb begin
      nib     = active_d[{idx_d, 2'b00} +: 4];
      blanked = blank_lz && (idx_d != '0) && zero_from[idx_d];
      seg_d   = seg_q;
      digit_d = digit_q;
      if (tick) begin
         seg_d   = (blanked || (blink_phase_q && blink_mask[idx_d])) ? 7'b1111111 : decode(nib);
         digit_d = ~(NUM_DIGITS'(1) << idx_d);
      end
   end

   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (blink_mask == '0) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end else begin
         blink_cnt_d   = blink_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         idx_q         <= IDX_LAST;
         shadow_q      <= '0;
         active_q      <= '0;
         seg_q         <= 7'b1111111;
         digit_q       <= '1;
      end else begin
         ref_q         <= ref_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         seg_q         <= seg_d;
         digit_q       <= digit_d;
      end
   end

   assign seg   = seg_q;
   assign digit = digit_q;

`ifdef SEVSEG_DP_EN
   logic dp_q;

   // Decimal point follows dp_mask live; blink and blanking do not apply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_q <= 1'b1;
      end else if (tick) begin
         dp_q <= ~dp_mask[idx_d];
      end
   end

   assign dp = dp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sevseg_scan_driver.sv
`default_nettype none
// Bench for sevseg_scan_driver: cycle-level reference model plus literal anchors.
module tb_sevseg_scan_driver;

   localparam int ND = 4;
   localparam int RD = 4;
   localparam int BD = 8;
   localparam logic [6:0] DEC [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   digits_in;
   logic          load;
   logic [3:0]    blink_mask;
   logic          blank_lz;
   logic [0:6]    seg;
   logic [3:0]    digit;

   int cmp_n = 0;
   int mis_n = 0;

   int          m_n, m_slot, m_bcnt;
   bit          m_phase, m_tick;
   logic [15:0] m_shadow, m_active;
   logic [6:0]  m_seg;
   logic [3:0]  m_dig;

   sevseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits_in  (digits_in),
      .load       (load),
      .blink_mask (blink_mask),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .digit      (digit)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_n = 0; m_slot = ND - 1; m_bcnt = 0; m_phase = 1'b0; m_tick = 1'b0;
      m_shadow = '0; m_active = '0; m_seg = 7'h7F; m_dig = 4'hF;
   endtask

   // One clock edge worth of behaviour, from inputs as sampled on that edge.
   task automatic model_edge();
      logic [3:0] nibv;
      bit         blank;
      m_n++;
      m_tick = (m_n % RD) == 0;
      if (m_tick) begin
         m_slot = (m_slot + 1) % ND;
         if (m_slot == 0) m_active = m_shadow;
         nibv  = 4'((m_active >> (4 * m_slot)) & 16'hF);
         blank = blank_lz && (m_slot > 0) && ((m_active >> (4 * m_slot)) == 16'h0);
         m_seg = (blank || (m_phase && blink_mask[m_slot])) ? 7'h7F : DEC[nibv];
         m_dig = ~(4'b0001 << m_slot);
      end
      if (load) m_shadow = digits_in;
      if (blink_mask == 4'h0) begin
         m_bcnt = 0; m_phase = 1'b0;
      end else begin
         m_bcnt++;
         if (m_bcnt == BD) begin
            m_bcnt = 0; m_phase = !m_phase;
         end
      end
   endtask

   task automatic check_model(string tag);
      cmp_n++;
      if (seg !== m_seg || digit !== m_dig) begin
         mis_n++;
         $display("FAIL %s t=%0t seg=%b digit=%b expected seg=%b digit=%b",
                  tag, $time, seg, digit, m_seg, m_dig);
      end
   endtask

   task automatic lit(string tag, logic [15:0] got, logic [15:0] exp);
      cmp_n++;
      if (got !== exp) begin
         mis_n++;
         $display("FAIL %s t=%0t got=%b expected=%b", tag, $time, got, exp);
      end
   endtask

   // Called at a negedge; returns at the next negedge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1 check_model("cycle");
      @(negedge clk);
   endtask

   task automatic to_slot(int s);
      int k = 0;
      do begin
         step();
         k++;
      end while (!(m_tick && m_slot == s) && k < 64);
      if (!(m_tick && m_slot == s)) begin
         cmp_n++; mis_n++;
         $display("FAIL slot_timeout waiting for slot %0d, got slot %0d", s, m_slot);
      end
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1 lit("async_rst_seg", 16'(seg), 16'h7F);
      lit("async_rst_digit", 16'(digit), 16'hF);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; digits_in = '0; load = 1'b0; blink_mask = '0; blank_lz = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      lit("reset_seg", 16'(seg), 16'h7F);
      lit("reset_digit", 16'(digit), 16'hF);
      rst_n = 1'b1;

      repeat (3) step();
      lit("pre_tick_digit", 16'(digit), 16'hF);
      step();
      lit("first_tick_digit", 16'(digit), 16'b1110);
      lit("first_tick_seg", 16'(seg), 16'b0000001);

      digits_in = 16'h1234; load = 1'b1; step(); load = 1'b0;
      to_slot(0); lit("s0_4", 16'(seg), 16'b1001100); lit("d0", 16'(digit), 16'b1110);
      to_slot(1); lit("s1_3", 16'(seg), 16'b0000110); lit("d1", 16'(digit), 16'b1101);
      to_slot(2); lit("s2_2", 16'(seg), 16'b0010010); lit("d2", 16'(digit), 16'b1011);
      to_slot(3); lit("s3_1", 16'(seg), 16'b1001111); lit("d3", 16'(digit), 16'b0111);

      to_slot(2);
      digits_in = 16'hABCD; load = 1'b1; step(); load = 1'b0;
      to_slot(3); lit("tear_s3_1", 16'(seg), 16'b1001111);
      to_slot(0); lit("new_s0_D", 16'(seg), 16'b1000010);
      to_slot(1); lit("new_s1_C", 16'(seg), 16'b0110001);
      to_slot(2); lit("new_s2_b", 16'(seg), 16'b1100000);
      to_slot(3); lit("new_s3_A", 16'(seg), 16'b0001000);

      blink_mask = 4'b0001;
      repeat (64) step();
      blink_mask = 4'b0000;
      to_slot(0); lit("blink_off_D", 16'(seg), 16'b1000010);

      blank_lz = 1'b1; digits_in = 16'h0050; load = 1'b1; step(); load = 1'b0;
      to_slot(0); lit("lz_s0", 16'(seg), 16'b0000001);
      to_slot(1); lit("lz_s1", 16'(seg), 16'b0100100);
      to_slot(2); lit("lz_s2", 16'(seg), 16'h7F);
      to_slot(3); lit("lz_s3", 16'(seg), 16'h7F); lit("lz_d3", 16'(digit), 16'b0111);
      digits_in = 16'h0000; load = 1'b1; step(); load = 1'b0;
      to_slot(0); lit("zero_s0", 16'(seg), 16'b0000001);
      to_slot(1); lit("zero_s1", 16'(seg), 16'h7F);

      to_slot(3);
      repeat (RD - 1) step();
      digits_in = 16'h0007; load = 1'b1; step(); load = 1'b0;
      lit("same_edge_old", 16'(seg), 16'b0000001);
      lit("same_edge_dig", 16'(digit), 16'b1110);
      to_slot(0); lit("same_edge_new", 16'(seg), 16'b0001111);

      step(); step();
      async_reset();
      repeat (RD) step();
      lit("post_rst_digit", 16'(digit), 16'b1110);

      for (int i = 0; i < 1500; i++) begin
         load = ($urandom_range(0, 7) == 0);
         if (load) begin
            for (int j = 0; j < 4; j++)
               digits_in[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         end
         if ($urandom_range(0, 49) == 0)
            blink_mask = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 299) == 0) async_reset();
         else step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
      $finish;
   end

endmodule
`default_nettype wire
